diferencial_receptor: RTL and testbench

- NRZI decoder at the receive end of the serial PCIe lane; counterpart to the differential emitter.
- Samples the incoming line level (D+) on every clock, synchronises it, and recovers the serial bit stream: a transition decodes as 1, no transition decodes as 0.
- Tracks link activity with a run-length counter. Drives RxValid / RxElecIdle toward the serial-to-parallel stage.
- Decoding reference level after reset is 0, matching the emitter's NRZI start value.

---
 rtl/diferencial_receptor.sv | 88 ++++++++
 tb/tb_diferencial_receptor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/diferencial_receptor.sv
// NRZI receiver for the serial lane: synchronises the line level, decodes
// transitions to 1s, and tracks link activity through a run-length counter.
//
// state    | meaning
// ---------+----------------------------------------------------------
// INACTIVO | electrical idle; waiting for the first decoded 1
// ACTIVO   | link active; counting consecutive decoded 0s toward idle
module diferencial_receptor #(
    parameter int IDLE_CYC = 16,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic enb,
    input  logic entrada,
    output logic salida,
    output logic RxValid,
    output logic RxElecIdle
);

    typedef enum logic {
        INACTIVO = 1'b0,
        ACTIVO   = 1'b1
    } estado_t;

    localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(IDLE_CYC - 1);

    logic             sync1;
    logic             sync2;
    logic             linea_prev;
    logic             bit_dec;
    logic             salida_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    estado_t          estado;
    estado_t          estado_nx;

    assign bit_dec = sync2 ^ linea_prev;

    // The synchroniser keeps tracking while disabled so re-enabling sees a
    // settled reference and cannot decode a stale transition.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            linea_prev <= 1'b0;
            salida     <= 1'b0;
            cnt        <= '0;
            estado     <= INACTIVO;
            RxValid    <= 1'b0;
            RxElecIdle <= 1'b1;
        end else begin
            sync1      <= entrada;
            sync2      <= sync1;
            linea_prev <= sync2;
            salida     <= salida_nx;
            cnt        <= cnt_nx;
            estado     <= estado_nx;
            RxValid    <= (estado_nx == ACTIVO);
            RxElecIdle <= (estado_nx != ACTIVO);
        end
    end

    always_comb begin
        estado_nx = estado;
        cnt_nx    = '0;
        salida_nx = 1'b0;
        if (!enb) begin
            estado_nx = INACTIVO;
        end else begin
            salida_nx = bit_dec;
            case (estado)
                INACTIVO: begin
                    if (bit_dec) estado_nx = ACTIVO;
                end
                ACTIVO: begin
                    // The IDLE_CYC-th consecutive 0 ends the active period.
                    if (!bit_dec) begin
                        if (cnt == CNT_FIN) estado_nx = INACTIVO;
                        else                cnt_nx    = cnt + 1'b1;
                    end
                end
                default: estado_nx = INACTIVO;
            endcase
        end
    end

endmodule

// File: tb/tb_diferencial_receptor.sv
// Scoreboard bench for diferencial_receptor: directed line levels with
// hand-computed decoded bits, link validity and idle counter values.
module tb_diferencial_receptor;

    logic clk = 1'b0;
    logic rst;
    logic enb;
    logic entrada;
    logic salida;
    logic RxValid;
    logic RxElecIdle;

    typedef struct {
        string tag;
        logic  sal;
        logic  vld;
        int    cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic cur   = 1'b0;
    bit   lv[$];
    int   runs[8] = '{5, 1, 3, 5, 2, 4, 5, 1};

    diferencial_receptor #(.IDLE_CYC(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .entrada   (entrada),
        .salida    (salida),
        .RxValid   (RxValid),
        .RxElecIdle(RxElecIdle)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue what the outputs must be after
    // the following rising edge (cnt < 0 means don't care).
    task automatic cyc(input string tag, input logic line, input logic en,
                       input logic r, input logic esal, input logic evld,
                       input int ecnt);
        exp_t e;
        @(negedge clk);
        entrada = line;
        enb     = en;
        rst     = r;
        e.tag   = tag;
        e.sal   = esal;
        e.vld   = evld;
        e.cnt   = ecnt;
        sb.push_back(e);
        cur = line;
    endtask

    task automatic chk(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %0d expected %0d", tag, what, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk(e.tag, "salida", {31'b0, salida}, {31'b0, e.sal});
                chk(e.tag, "RxValid", {31'b0, RxValid}, {31'b0, e.vld});
                chk(e.tag, "RxElecIdle", {31'b0, RxElecIdle}, {31'b0, !e.vld});
                if (e.cnt >= 0) chk(e.tag, "cnt", {24'b0, dut.cnt}, e.cnt);
            end
        end
    end

    initial begin
        int   w;
        int   k;
        int   r;
        int   left;
        logic level;
        logic c;

        rst = 1'b0; enb = 1'b1; entrada = 1'b0;
        w = 0;

        // reset held 3 edges with the line toggling
        cyc("rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        cyc("rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        cyc("rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // line 0,1,1,0,0,0,1 then held 1 -> salida 0,1,0,1,0,0,1 two edges late
        cyc("dec", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc("dec", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc("dec", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc("dec", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        cyc("dec", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        cyc("dec", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        cyc("dec", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        cyc("dec", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2);
        cyc("dec", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0);

        // 15 constant cycles keep the link up, the 16th drops it
        for (int i = 1; i <= 15; i++)
            cyc("idle_run", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, i);
        cyc("idle_drop", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc("wake", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc("wake", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc("wake", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);

        // runs of at most 5 equal levels; reference decode from the level history
        lv.push_back(1'b0); lv.push_back(1'b0); lv.push_back(1'b0);
        level = 1'b1;
        r     = 0;
        left  = runs[0];
        for (int i = 0; i < 200; i++) begin
            lv.push_back(level);
            k = lv.size() - 1;
            cyc("run5", level, 1'b1, 1'b1, lv[k-2] ^ lv[k-3], 1'b1, -1);
            left--;
            if (left == 0) begin
                r     = (r + 1) % 8;
                left  = runs[r];
                level = !level;
            end
        end

        // enable gap: line toggles early in the gap, then settles
        c = cur;
        cyc("gap", !c, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cyc("gap",  c, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cyc("gap",  c, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cyc("gap",  c, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cyc("reen", c, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc("reen", c, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc("reen", c, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc("wake2", !c, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc("wake2", !c, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc("wake2", !c, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        for (int j = 1; j <= 7; j++)
            cyc("hold", !c, 1'b1, 1'b1, 1'b0, 1'b1, j);

        // one-edge reset mid-stream at cnt=7; line=1 afterwards decodes vs reference 0
        cyc("rst_mid", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        cyc("post", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc("post", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc("post", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0);

        while (sb.size() != 0 && w < 10) begin
            @(posedge clk);
            #2;
            w++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
